// File: rtl/gate_bank_checker.sv
// gate_bank_checker
//   Self-test sequencer for the two-input gate bank (AND, OR, XOR, NOT,
//   NAND, NOR, EXNOR). On start it presents the four (a,b) combinations in
//   order 00,01,10,11. Each combination is held for SETTLE_CYCLES cycles and
//   then sampled for one cycle. Every sample of y is compared with the
//   expected gate values, and the pass/fail results accumulate.
//
// Ports
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle request; accepted only when not busy
//   a, b       registered drive to the gate bank inputs
//   y[6:0]     gate bank outputs {EXNOR,NOR,NAND,NOT,XOR,OR,AND}
//   busy       sequence in progress
//   done       sequence complete; held until the next accepted start
//   pass       valid with done; 1 when no vector mismatched
//   err_count  number of mismatching vectors (0..4)
//   err_mask   sticky OR of mismatching y bits
//   fail_vec   bit k set when vector k ({a,b}=k) mismatched
module gate_bank_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [6:0] err_mask,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       vec;
    logic [1:0]       vec_inc;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       expected;
    logic [6:0]       mismatch;

    // Expected values come from the registered a/b. During SAMPLE these
    // registers still hold the vector under test.
    // The per-bit case-inequality makes an X or Z on y count as a mismatch.
    always_comb begin
        expected = {~(a ^ b), ~(a | b), ~(a & b), ~a, a ^ b, a | b, a & b};
        mismatch = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            mismatch[i] = (y[i] !== expected[i]);
        end
    end

    always_comb begin
        vec_inc = vec + 2'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SETTLE;
            SETTLE:     if (cnt == CNT_LAST) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = (vec == 2'd3) ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == 3'd0);
    end

    // Datapath: vector index, settle counter, a/b drive and result registers.
    // a/b are loaded only when SETTLE is entered. In DONE they keep the last
    // vector (1,1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            err_count <= '0;
            err_mask  <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec       <= '0;
                        cnt       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        err_count <= '0;
                        err_mask  <= '0;
                        fail_vec  <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    err_mask <= err_mask | mismatch;
                    if (|mismatch) begin
                        fail_vec[vec] <= 1'b1;
                        err_count     <= err_count + 3'd1;
                    end
                    if (vec != 2'd3) begin
                        vec <= vec_inc;
                        cnt <= '0;
                        a   <= vec_inc[1];
                        b   <= vec_inc[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bank_checker.sv
// Testbench for gate_bank_checker.
//   dut     : default SETTLE_CYCLES=2. It is driven through a gate model
//             that is either correct, has AND stuck at 0, or has NOT
//             replaced by a. A behavioural model predicts all of its
//             outputs on every cycle.
//   dut_s1  : SETTLE_CYCLES=1. Its gate bank output lags the inputs by
//             2 cycles.
//   dut_s3  : SETTLE_CYCLES=3. Its gate bank has the same 2-cycle lag.
module tb_gate_bank_checker;

    localparam int S = 2;
    localparam int L = 4 * (S + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_d = 1'b0;
    int   mode = 0;

    logic       dut_a, dut_b, dut_busy, dut_done, dut_pass;
    logic [6:0] dut_y, dut_mask;
    logic [2:0] dut_cnt;
    logic [3:0] dut_fv;

    logic       s1_a, s1_b, s1_busy, s1_done, s1_pass;
    logic [6:0] s1_y, s1_mask;
    logic [2:0] s1_cnt;
    logic [3:0] s1_fv;

    logic       s3_a, s3_b, s3_busy, s3_done, s3_pass;
    logic [6:0] s3_y, s3_mask;
    logic [2:0] s3_cnt;
    logic [3:0] s3_fv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] gates(input logic ga, input logic gb);
        return {~(ga ^ gb), ~(ga | gb), ~(ga & gb), ~ga, ga ^ gb, ga | gb, ga & gb};
    endfunction

    // Gate bank variants. 0 = correct, 1 = AND stuck at 0, 2 = NOT output equals a.
    function automatic logic [6:0] faulty(input int md, input logic ga, input logic gb);
        logic [6:0] g;
        g = gates(ga, gb);
        if (md == 1) g[0] = 1'b0;
        else if (md == 2) g[3] = ga;
        return g;
    endfunction

    // Results after the first nvec vectors are sampled: {count, mask, fail_vec}.
    function automatic logic [13:0] accum(input int md, input int nvec);
        logic [2:0] c;
        logic [6:0] m;
        logic [3:0] f;
        logic [6:0] mis;
        logic [1:0] kk;
        c = '0; m = '0; f = '0;
        for (int k = 0; k < nvec; k++) begin
            kk = k[1:0];
            mis = faulty(md, kk[1], kk[0]) ^ gates(kk[1], kk[0]);
            m = m | mis;
            if (|mis) begin
                c = c + 3'd1;
                f[kk] = 1'b1;
            end
        end
        return {c, m, f};
    endfunction

    always_comb dut_y = faulty(mode, dut_a, dut_b);

    // Gate banks with two cycles of output delay.
    logic [1:0] p1_s1, p2_s1, p1_s3, p2_s3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_s1 <= '0; p2_s1 <= '0; p1_s3 <= '0; p2_s3 <= '0;
        end else begin
            p1_s1 <= {s1_a, s1_b}; p2_s1 <= p1_s1;
            p1_s3 <= {s3_a, s3_b}; p2_s3 <= p1_s3;
        end
    end
    always_comb s1_y = gates(p2_s1[1], p2_s1[0]);
    always_comb s3_y = gates(p2_s3[1], p2_s3[0]);

    gate_bank_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(dut_a), .b(dut_b), .y(dut_y),
        .busy(dut_busy), .done(dut_done), .pass(dut_pass),
        .err_count(dut_cnt), .err_mask(dut_mask), .fail_vec(dut_fv)
    );

    gate_bank_checker #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_d), .a(s1_a), .b(s1_b), .y(s1_y),
        .busy(s1_busy), .done(s1_done), .pass(s1_pass),
        .err_count(s1_cnt), .err_mask(s1_mask), .fail_vec(s1_fv)
    );

    gate_bank_checker #(.SETTLE_CYCLES(3), .CNT_W(8)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_d), .a(s3_a), .b(s3_b), .y(s3_y),
        .busy(s3_busy), .done(s3_done), .pass(s3_pass),
        .err_count(s3_cnt), .err_mask(s3_mask), .fail_vec(s3_fv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the main dut: run timeline only, as elapsed cycles since the accepted start.
    bit m_started = 1'b0;
    bit m_active  = 1'b0;
    int m_cyc     = 0;
    int m_mode    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_active  <= 1'b0;
            m_cyc     <= 0;
        end else if (start && !m_active) begin
            m_started <= 1'b1;
            m_active  <= 1'b1;
            m_cyc     <= 0;
            m_mode    <= mode;
        end else if (m_active) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == L) m_active <= 1'b0;
        end
    end

    // Compare the main dut against the model on every falling edge.
    always @(negedge clk) begin
        logic [18:0] exp_v;
        logic [18:0] act_v;
        logic [13:0] r;
        int v;
        if (!m_started) begin
            exp_v = '0;
        end else if (m_active) begin
            v = m_cyc / (S + 1);
            r = accum(m_mode, v);
            exp_v = {v[1], v[0], 1'b1, 1'b0, 1'b0, r};
        end else begin
            r = accum(m_mode, 4);
            exp_v = {2'b11, 1'b0, 1'b1, (r[13:11] == 3'd0), r};
        end
        act_v = {dut_a, dut_b, dut_busy, dut_done, dut_pass, dut_cnt, dut_mask, dut_fv};
        check("cycle_model", 32'(act_v), 32'(exp_v));
    end

    // Start a run on the main dut. Optionally pulse start again at elapsed
    // cycle rp. cyc returns the elapsed cycle where done rose (0 = timeout).
    task automatic run(input int md, input int rp, output int cyc);
        mode = md;
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = (k == rp);
            if (dut_done) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int t1;
        int t3;
        repeat (2) @(negedge clk);
        check("reset_state", 32'({dut_a, dut_b, dut_busy, dut_done, dut_pass, dut_cnt, dut_mask, dut_fv}), 32'd0);
        #2 rst_n = 1'b1;

        // Correct gate bank
        run(0, 0, cyc);
        check("latency_good", 32'(cyc), 32'd12);
        check("pass_good", 32'(dut_pass), 32'd1);
        check("errcnt_good", 32'(dut_cnt), 32'd0);

        // AND stuck at 0
        run(1, 0, cyc);
        check("latency_and0", 32'(cyc), 32'd12);
        check("failvec_and0", 32'(dut_fv), 32'b1000);
        check("errcnt_and0", 32'(dut_cnt), 32'd1);
        check("mask_and0", 32'(dut_mask), 32'b0000001);
        check("pass_and0", 32'(dut_pass), 32'd0);

        // NOT inverted
        run(2, 0, cyc);
        check("failvec_not", 32'(dut_fv), 32'b1111);
        check("errcnt_not", 32'(dut_cnt), 32'd4);
        check("mask_not", 32'(dut_mask), 32'b0001000);

        // Restart from DONE clears results; a second start while busy is ignored
        run(0, 5, cyc);
        check("latency_repulse", 32'(cyc), 32'd12);
        check("pass_repulse", 32'(dut_pass), 32'd1);
        check("failvec_repulse", 32'(dut_fv), 32'd0);

        // Reset in the middle of a run
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({dut_a, dut_b, dut_busy, dut_done, dut_pass, dut_cnt, dut_mask, dut_fv}), 32'd0);
        repeat (3) @(negedge clk);
        check("done_in_reset", 32'(dut_done), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("done_after_reset", 32'(dut_done), 32'd0);
        run(0, 0, cyc);
        check("latency_after_reset", 32'(cyc), 32'd12);
        check("pass_after_reset", 32'(dut_pass), 32'd1);

        // Delayed gate bank against SETTLE_CYCLES=1 and SETTLE_CYCLES=3
        t1 = 0; t3 = 0;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (s1_done && t1 == 0) t1 = k;
            if (s3_done && t3 == 0) t3 = k;
            if (t1 != 0 && t3 != 0) break;
        end
        check("latency_s1", 32'(t1), 32'd8);
        check("pass_s1", 32'(s1_pass), 32'd0);
        check("failvec_s1", 32'(s1_fv), 32'b1110);
        check("errcnt_s1", 32'(s1_cnt), 32'd3);
        check("mask_s1", 32'(s1_mask), 32'h7f);
        check("latency_s3", 32'(t3), 32'd16);
        check("pass_s3", 32'(s3_pass), 32'd1);
        check("failvec_s3", 32'(s3_fv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
